// File: rtl/instr_fetch.sv
// ----------------------------------------------------------------------------
// instr_fetch
//
// Instruction fetch stage for the 8-bit training CPU. It owns the 13-bit
// program counter, reads two consecutive bytes from the instruction ROM and
// assembles them into a 16-bit instruction (3-bit opcode, 13-bit operand
// address). It then offers that instruction downstream through a valid/ready
// handshake. Jump redirects and halt requests are taken only on the edge
// where the instruction is accepted.
//
// Ports:
//   clk        - system clock; all state changes on its rising edge
//   reset      - asynchronous, active-high reset
//   rom_addr   - ROM byte address (always equal to pc)
//   rom_read   - ROM read strobe, high in FETCH_HI and FETCH_LO only
//   rom_ena    - ROM enable (always equal to rom_read)
//   rom_data   - combinational ROM data for rom_addr
//   ir_valid   - registered; a complete instruction is on ir_opcode/ir_addr
//   ir_ready   - consumer takes the instruction this cycle
//   ir_opcode  - instruction bits [15:13]
//   ir_addr    - instruction bits [12:0]
//   jump       - redirect request, honoured only on the accept edge
//   jump_addr  - redirect target (any alignment)
//   halt       - stop request, honoured only on the accept edge (beats jump)
//   pc         - current program counter
//   halted     - the fetch stage has stopped and waits for reset
// ----------------------------------------------------------------------------
module instr_fetch #(
   parameter logic [12:0] RESET_PC = 13'h0000
) (
   input  logic        clk,
   input  logic        reset,
   output logic [12:0] rom_addr,
   output logic        rom_read,
   output logic        rom_ena,
   input  logic [7:0]  rom_data,
   output logic        ir_valid,
   input  logic        ir_ready,
   output logic [2:0]  ir_opcode,
   output logic [12:0] ir_addr,
   input  logic        jump,
   input  logic [12:0] jump_addr,
   input  logic        halt,
   output logic [12:0] pc,
   output logic        halted
);

   typedef enum logic [2:0] {
      START,
      FETCH_HI,
      FETCH_LO,
      HOLD,
      HALTED
   } state_t;

   state_t state;
   state_t next_state;
   logic   accept;

   // The handshake completes only while an instruction is actually held;
   // a ready from the consumer in any other cycle has no effect.
   assign accept = (state == HOLD) && ir_valid && ir_ready;

   // ROM controls depend only on the state register and pc, so they cannot
   // glitch in response to the handshake, jump or halt inputs.
   assign rom_read = (state == FETCH_HI) || (state == FETCH_LO);
   assign rom_ena  = rom_read;
   assign rom_addr = pc;
   assign halted   = (state == HALTED);

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= START;
      end else begin
         state <= next_state;
      end
   end

   // Next-state logic. START is a single idle cycle that gives the ROM time
   // after reset release; HALTED is only left through reset.
   always_comb begin
      next_state = state;
      case (state)
         START:    next_state = FETCH_HI;
         FETCH_HI: next_state = FETCH_LO;
         FETCH_LO: next_state = HOLD;
         HOLD: begin
            if (accept) begin
               next_state = halt ? HALTED : FETCH_HI;
            end
         end
         HALTED:   next_state = HALTED;
         default:  next_state = START;
      endcase
   end

   // Datapath: program counter, instruction register and the valid flag.
   // pc advances once per byte read and wraps modulo 2^13, so an instruction
   // whose high byte sits at 13'h1FFF takes its low byte from 13'h0000.
   // On an accepted halt pc is left alone; on an accepted jump it is loaded
   // with the target so the next FETCH_HI reads the target immediately.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pc        <= RESET_PC;
         ir_opcode <= 3'b000;
         ir_addr   <= 13'h0000;
         ir_valid  <= 1'b0;
      end else begin
         case (state)
            FETCH_HI: begin
               ir_opcode     <= rom_data[7:5];
               ir_addr[12:8] <= rom_data[4:0];
               pc            <= pc + 13'd1;
            end
            FETCH_LO: begin
               ir_addr[7:0] <= rom_data;
               pc           <= pc + 13'd1;
               ir_valid     <= 1'b1;
            end
            HOLD: begin
               if (accept) begin
                  ir_valid <= 1'b0;
                  if (!halt && jump) begin
                     pc <= jump_addr;
                  end
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_instr_fetch.sv
// ----------------------------------------------------------------------------
// tb_instr_fetch
//
// Self-checking bench for instr_fetch. A byte array stands in for the
// instruction ROM. Directed sequences cover reset, backpressure, halt and
// asynchronous reset; a table of jump targets covers redirects including
// odd targets and the 13'h1FFF wrap; a randomized phase compares every
// accepted instruction against a transaction-level model that only knows
// "instruction at address p is {rom[p], rom[p+1]}, next p is p+2 or the
// jump target".
// ----------------------------------------------------------------------------
module tb_instr_fetch;

   logic        clk;
   logic        reset;
   logic [12:0] rom_addr;
   logic        rom_read;
   logic        rom_ena;
   logic [7:0]  rom_data;
   logic        ir_valid;
   logic        ir_ready;
   logic [2:0]  ir_opcode;
   logic [12:0] ir_addr;
   logic        jump;
   logic [12:0] jump_addr;
   logic        halt;
   logic [12:0] pc;
   logic        halted;

   logic [7:0]  rom [0:8191];

   int n_checks;
   int n_pass;

   typedef struct {
      logic [12:0] target;
      logic [7:0]  hi;
      logic [7:0]  lo;
      logic [2:0]  exp_op;
      logic [12:0] exp_addr;
      logic [12:0] exp_pc;
   } vec_t;

   vec_t vecs [5];

   instr_fetch #(.RESET_PC(13'h0000)) dut (
      .clk       (clk),
      .reset     (reset),
      .rom_addr  (rom_addr),
      .rom_read  (rom_read),
      .rom_ena   (rom_ena),
      .rom_data  (rom_data),
      .ir_valid  (ir_valid),
      .ir_ready  (ir_ready),
      .ir_opcode (ir_opcode),
      .ir_addr   (ir_addr),
      .jump      (jump),
      .jump_addr (jump_addr),
      .halt      (halt),
      .pc        (pc),
      .halted    (halted)
   );

   // Combinational ROM model.
   assign rom_data = rom[rom_addr];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] act,
                              input logic [31:0] exp);
      n_checks++;
      if (act === exp) begin
         n_pass++;
      end else begin
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t",
                  name, act, exp, $time);
      end
   endtask

   // Holds reset for a cycle, checks reset values, releases on a negedge.
   // Returns in the START cycle.
   task automatic applyStimulus();
      reset    = 1'b1;
      ir_ready = 1'b0;
      jump     = 1'b0;
      halt     = 1'b0;
      @(negedge clk);
      checkOutput("rst_rom_read", {31'd0, rom_read}, 32'd0);
      checkOutput("rst_rom_ena", {31'd0, rom_ena}, 32'd0);
      checkOutput("rst_pc", {19'd0, pc}, 32'h0);
      checkOutput("rst_ir_valid", {31'd0, ir_valid}, 32'd0);
      checkOutput("rst_halted", {31'd0, halted}, 32'd0);
      @(negedge clk);
      reset = 1'b0;
   endtask

   // Bounded wait for a held instruction; sample #1 after the clock edge.
   task automatic waitValid();
      for (int i = 0; i < 6 && !ir_valid; i++) begin
         @(posedge clk);
         #1;
      end
      checkOutput("wait_valid", {31'd0, ir_valid}, 32'd1);
   endtask

   initial begin
      logic [12:0] lo_a;
      logic [12:0] model_ptr;
      logic [12:0] exp_pc;
      logic        r_ready;
      logic        r_jump;
      logic [12:0] r_addr;
      int          idle;
      int          max_idle;
      int          n_accept;

      n_checks  = 0;
      n_pass    = 0;
      reset     = 1'b1;
      ir_ready  = 1'b0;
      jump      = 1'b0;
      halt      = 1'b0;
      jump_addr = 13'h0000;
      for (int i = 0; i < 8192; i++) rom[i] = 8'h00;

      vecs[0] = '{13'h0100, 8'hE0, 8'h05, 3'b111, 13'h0005, 13'h0102};
      vecs[1] = '{13'h1FFF, 8'h40, 8'h7F, 3'b010, 13'h007F, 13'h0001};
      vecs[2] = '{13'h0333, 8'h3C, 8'h99, 3'b001, 13'h1C99, 13'h0335};
      vecs[3] = '{13'h1ABC, 8'hFF, 8'hFF, 3'b111, 13'h1FFF, 13'h1ABE};
      vecs[4] = '{13'h0010, 8'h00, 8'h00, 3'b000, 13'h0000, 13'h0012};

      // Reset and sequential fetch
      rom[0] = 8'hA1;
      rom[1] = 8'h23;
      rom[2] = 8'h5A;
      rom[3] = 8'hC3;
      applyStimulus();
      checkOutput("start_rom_read", {31'd0, rom_read}, 32'd0);
      @(posedge clk); #1;
      checkOutput("fhi_rom_read", {31'd0, rom_read}, 32'd1);
      checkOutput("fhi_rom_ena", {31'd0, rom_ena}, 32'd1);
      checkOutput("fhi_rom_addr", {19'd0, rom_addr}, 32'h0);
      checkOutput("fhi_ir_valid", {31'd0, ir_valid}, 32'd0);
      @(posedge clk); #1;
      checkOutput("flo_rom_addr", {19'd0, rom_addr}, 32'h1);
      @(posedge clk); #1;
      checkOutput("first_valid", {31'd0, ir_valid}, 32'd1);
      checkOutput("first_opcode", {29'd0, ir_opcode}, 32'h5);
      checkOutput("first_addr", {19'd0, ir_addr}, 32'h0123);
      checkOutput("first_pc", {19'd0, pc}, 32'h2);

      // Backpressure, with a jump offered while not ready (must be ignored)
      jump      = 1'b1;
      jump_addr = 13'h0AAA;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         checkOutput("bp_valid", {31'd0, ir_valid}, 32'd1);
         checkOutput("bp_rom_read", {31'd0, rom_read}, 32'd0);
         checkOutput("bp_pc", {19'd0, pc}, 32'h2);
         checkOutput("bp_opcode", {29'd0, ir_opcode}, 32'h5);
         checkOutput("bp_addr", {19'd0, ir_addr}, 32'h0123);
      end
      jump     = 1'b0;
      ir_ready = 1'b1;
      @(posedge clk); #1;
      ir_ready = 1'b0;
      checkOutput("acc_valid_drop", {31'd0, ir_valid}, 32'd0);
      checkOutput("acc_rom_read", {31'd0, rom_read}, 32'd1);
      checkOutput("acc_rom_addr", {19'd0, rom_addr}, 32'h2);
      waitValid();
      checkOutput("seq_opcode", {29'd0, ir_opcode}, 32'h2);
      checkOutput("seq_addr", {19'd0, ir_addr}, 32'h1AC3);
      checkOutput("seq_pc", {19'd0, pc}, 32'h4);

      // Jump table
      for (int v = 0; v < 5; v++) begin
         waitValid();
         lo_a = vecs[v].target + 13'd1;
         rom[vecs[v].target] = vecs[v].hi;
         rom[lo_a]           = vecs[v].lo;
         jump      = 1'b1;
         jump_addr = vecs[v].target;
         ir_ready  = 1'b1;
         @(posedge clk); #1;
         jump      = 1'b0;
         ir_ready  = 1'b0;
         checkOutput("jmp_rom_read", {31'd0, rom_read}, 32'd1);
         checkOutput("jmp_rom_addr", {19'd0, rom_addr}, {19'd0, vecs[v].target});
         waitValid();
         checkOutput("jmp_opcode", {29'd0, ir_opcode}, {29'd0, vecs[v].exp_op});
         checkOutput("jmp_addr", {19'd0, ir_addr}, {19'd0, vecs[v].exp_addr});
         checkOutput("jmp_pc", {19'd0, pc}, {19'd0, vecs[v].exp_pc});
      end

      // Halt beats jump
      halt      = 1'b1;
      jump      = 1'b1;
      jump_addr = 13'h0555;
      ir_ready  = 1'b1;
      @(posedge clk); #1;
      for (int i = 0; i < 10; i++) begin
         checkOutput("halt_halted", {31'd0, halted}, 32'd1);
         checkOutput("halt_rom_read", {31'd0, rom_read}, 32'd0);
         checkOutput("halt_valid", {31'd0, ir_valid}, 32'd0);
         checkOutput("halt_pc", {19'd0, pc}, {19'd0, vecs[4].exp_pc});
         ir_ready = 1'($urandom_range(0, 1));
         jump     = 1'($urandom_range(0, 1));
         halt     = 1'($urandom_range(0, 1));
         @(posedge clk); #1;
      end

      // Reset restarts fetch from RESET_PC; then reset mid-fetch
      rom[0] = 8'hA1;
      rom[1] = 8'h23;
      applyStimulus();
      checkOutput("restart_halted", {31'd0, halted}, 32'd0);
      @(posedge clk); #1;
      checkOutput("restart_addr", {19'd0, rom_addr}, 32'h0);
      @(posedge clk); #1;
      checkOutput("mid_in_flo", {19'd0, rom_addr}, 32'h1);
      #2 reset = 1'b1;
      #1;
      checkOutput("async_rom_read", {31'd0, rom_read}, 32'd0);
      checkOutput("async_pc", {19'd0, pc}, 32'h0);
      checkOutput("async_opcode", {29'd0, ir_opcode}, 32'h0);
      checkOutput("async_addr", {19'd0, ir_addr}, 32'h0);
      checkOutput("async_valid", {31'd0, ir_valid}, 32'd0);
      @(negedge clk);
      reset = 1'b0;
      checkOutput("post_rst_idle", {31'd0, rom_read}, 32'd0);
      @(posedge clk); #1;
      checkOutput("post_rst_read", {31'd0, rom_read}, 32'd1);
      checkOutput("post_rst_addr", {19'd0, rom_addr}, 32'h0);

      // Reset while holding an instruction drops ir_valid immediately
      waitValid();
      #2 reset = 1'b1;
      #1;
      checkOutput("async_hold_valid", {31'd0, ir_valid}, 32'd0);

      // Randomized phase against the transaction-level model
      for (int i = 0; i < 8192; i++) rom[i] = 8'($urandom);
      applyStimulus();
      @(posedge clk); #1;
      model_ptr = 13'h0000;
      idle      = 0;
      max_idle  = 0;
      n_accept  = 0;
      for (int cyc = 0; cyc < 400; cyc++) begin
         r_ready = ($urandom_range(0, 3) != 0);
         r_jump  = ($urandom_range(0, 3) == 0);
         r_addr  = 13'($urandom);
         ir_ready  = r_ready;
         jump      = r_jump;
         jump_addr = r_addr;
         if (ir_valid) begin
            idle = 0;
            exp_pc = model_ptr + 13'd2;
            checkOutput("rnd_pc", {19'd0, pc}, {19'd0, exp_pc});
         end else begin
            idle++;
            if (idle > max_idle) max_idle = idle;
         end
         if (ir_valid && r_ready) begin
            halt = 1'b0;
            lo_a = model_ptr + 13'd1;
            checkOutput("rnd_opcode", {29'd0, ir_opcode}, {29'd0, rom[model_ptr][7:5]});
            checkOutput("rnd_addr", {19'd0, ir_addr},
                        {19'd0, rom[model_ptr][4:0], rom[lo_a]});
            model_ptr = r_jump ? r_addr : model_ptr + 13'd2;
            n_accept++;
         end else begin
            halt = 1'($urandom_range(0, 1));
         end
         @(posedge clk); #1;
      end
      checkOutput("rnd_max_gap", max_idle, 32'd2);
      checkOutput("rnd_halted", {31'd0, halted}, 32'd0);

      // Final accepted halt in the random stream
      waitValid();
      exp_pc    = model_ptr + 13'd2;
      halt      = 1'b1;
      jump      = 1'b1;
      ir_ready  = 1'b1;
      @(posedge clk); #1;
      halt     = 1'b0;
      jump     = 1'b0;
      ir_ready = 1'b0;
      checkOutput("rnd_end_halted", {31'd0, halted}, 32'd1);
      checkOutput("rnd_end_pc", {19'd0, pc}, {19'd0, exp_pc});

      $display("[TB] %0d accepted instructions in random phase", n_accept);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   // Hard bound on run time.
   initial begin
      #200000;
      $display("[TB] FAIL timeout: got running expected finished");
      $fatal(1, "[TB] timeout");
   end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch stage for the 8-bit training CPU, sitting directly upstream of the instruction ROM. It owns the 13-bit program counter and drives the ROM's `addr`, `read` and `ena` inputs. It assembles two consecutive ROM bytes into one 16-bit instruction (3-bit opcode, 13-bit operand address). It then offers the instruction to the execute/controller stage through a valid/ready handshake, and accepts jump redirects and halt at handshake time.

## Interface
Parameters:
- `RESET_PC`, default 13'h0000: PC value loaded on reset.

Ports:
- `clk`, in, 1: single system clock; all state updates on its rising edge.
- `reset`, in, 1: asynchronous, active-high reset.
- `rom_addr`, out, 13: ROM byte address; always equals `pc`.
- `rom_read`, out, 1: ROM read strobe.
- `rom_ena`, out, 1: ROM enable; always equal to `rom_read`.
- `rom_data`, in, 8: ROM data. Combinational from `rom_addr`, and valid in the same cycle when `rom_read && rom_ena`.
- `ir_valid`, out, 1: a complete instruction is held on `ir_opcode`/`ir_addr`.
- `ir_ready`, in, 1: consumer accepts the instruction this cycle.
- `ir_opcode`, out, 3: instruction bits [15:13].
- `ir_addr`, out, 13: instruction bits [12:0].
- `jump`, in, 1: redirect request; sampled only on the accept edge.
- `jump_addr`, in, 13: redirect target.
- `halt`, in, 1: stop request; sampled only on the accept edge.
- `pc`, out, 13: current program counter, for debug and the controller.
- `halted`, out, 1: the block is in HALTED.

## Operation
- FSM states: START, FETCH_HI, FETCH_LO, HOLD, HALTED.
- START:
  - `rom_read` = 0.
  - Advances unconditionally to FETCH_HI on the next edge.
  - Gives the ROM one idle cycle after reset release.
- FETCH_HI:
  - `rom_read` = `rom_ena` = 1, `rom_addr` = `pc`.
  - At the edge: `ir_opcode` ← `rom_data[7:5]`, `ir_addr[12:8]` ← `rom_data[4:0]`, `pc` ← `pc`+1, go to FETCH_LO.
- FETCH_LO:
  - Read enabled.
  - At the edge: `ir_addr[7:0]` ← `rom_data`, `pc` ← `pc`+1, go to HOLD.
- HOLD:
  - `ir_valid` = 1 and `rom_read` = 0.
  - `ir_opcode` and `ir_addr` are stable until accepted.
  - Accept = `ir_valid && ir_ready` at a rising edge.
- On accept, priority is halt > jump > sequential:
  - `halt` = 1: go to HALTED, `pc` unchanged.
  - else `jump` = 1: `pc` ← `jump_addr`, go to FETCH_HI.
  - else: go to FETCH_HI with `pc` as already incremented.
- HALTED:
  - `rom_read` = 0, `ir_valid` = 0, `halted` = 1.
  - Left only by `reset`.
- `ir_valid` is a registered output. It is set on the FETCH_LO→HOLD edge and cleared on the accept edge.
- `ir_ready` without `ir_valid` is ignored.
- `jump` and `halt` are ignored outside the accept edge.
- PC arithmetic is modulo 2^13:
  - 13'h1FFF + 1 = 13'h0000, with no flag.
  - An instruction whose high byte is at 13'h1FFF takes its low byte from 13'h0000.
- `jump_addr` may be odd. No alignment is enforced.

## Timing
- Reset values (asynchronous):
  - state = START, `pc` = `rom_addr` = RESET_PC.
  - `rom_read` = `rom_ena` = 0, `ir_valid` = 0.
  - `ir_opcode` = 0, `ir_addr` = 0, `halted` = 0.
- Reset asserted mid-fetch or in HOLD: the partial or held instruction is discarded immediately, and `ir_valid` drops asynchronously.
- First read: FETCH_HI is the 2nd rising edge after reset release. `ir_valid` rises after the 3rd edge.
- Steady-state throughput with `ir_ready` tied high: one instruction per 3 cycles (FETCH_HI, FETCH_LO, HOLD).
- Redirect latency: the target's high byte is read in the cycle immediately after the accept edge.
- `rom_read`, `rom_ena` and `rom_addr` are decoded from state and `pc` only, never from `ir_ready`, `jump` or `halt`. They are glitch-free with respect to the inputs.

## Test plan
- Reset and sequential fetch:
  - Stimulus: ROM[0]=8'hA1, ROM[1]=8'h23, `ir_ready`=1.
  - Required: `rom_read`=0 through the START cycle; `ir_opcode`=3'b101 and `ir_addr`=13'h0123 with `ir_valid`=1 after the 3rd edge; `pc`=2.
- Backpressure:
  - Stimulus: hold `ir_ready`=0 for 5 cycles in HOLD.
  - Required: `ir_valid` stays 1, outputs stable, `rom_read`=0, `pc` stays 2. Raising `ir_ready` for one cycle makes `ir_valid` fall and the next FETCH_HI read `rom_addr`=2.
- Jump:
  - Stimulus: accept with `jump`=1, `jump_addr`=13'h0100, ROM[100]=8'hE0, ROM[101]=8'h05.
  - Required: next `rom_addr`=13'h0100; instruction opcode 3'b111 with `ir_addr`=13'h0005.
  - Also: `jump`=1 while `ir_ready`=0 is ignored.
- Halt beats jump:
  - Stimulus: accept with `halt`=1 and `jump`=1.
  - Required: `halted`=1, `pc` unchanged, `rom_read` stays 0 for 10 cycles; only `reset` restarts fetch at RESET_PC.
- Wrap:
  - Stimulus: jump to 13'h1FFF with ROM[1FFF]=8'h40, ROM[0]=8'h7F.
  - Required: `ir_addr`=13'h007F, opcode 3'b010, `pc`=13'h0001.
- Async reset mid-fetch:
  - Stimulus: assert `reset` in FETCH_LO between clock edges.
  - Required: all outputs take reset values immediately; after release, `rom_read`=0 for one cycle and the fetch restarts at RESET_PC.
